// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider with a shadow ratio that retunes only at period boundaries.
// Defining CLK_DIV_PROG_TICK_EN adds the o_tick clock-enable output.
module clk_div_prog #(
  parameter int RATIO_W = 8
) (
  input  logic               ref_clk,
  input  logic               rst,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio,
  output logic               o_clk,
  output logic               div_active,
  output logic               ratio_ld
`ifdef CLK_DIV_PROG_TICK_EN
  , output logic             o_tick
`endif
);

  localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] TWO = RATIO_W'(2);

  logic [RATIO_W-1:0] r_shadow;
  logic [RATIO_W-1:0] r_cnt;
  logic               r_clk_q;
  logic               r_div_active;
  logic               r_ratio_ld;

  logic               w_dv;
  logic               w_wrap;
  logic               w_load;
  logic [RATIO_W-1:0] w_nm1;
  logic [RATIO_W-1:0] w_half;
  logic [RATIO_W-1:0] w_cnt_inc;

  // Mode decode and period-boundary detection; the shadow reloads whenever bypassing or at a wrap.
  always_comb begin
    w_nm1     = r_shadow - ONE;
    w_half    = r_shadow >> 1'b1;
    w_cnt_inc = r_cnt + ONE;
    w_dv      = en & (r_shadow >= TWO);
    w_wrap    = w_dv & (r_cnt == w_nm1);
    w_load    = ~w_dv | w_wrap;
  end

  // Period counter and divided clock: low for the first floor(N/2) counts, high for the rest.
  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_clk_q <= 1'b0;
    end else if (w_load) begin
      r_cnt   <= '0;
      r_clk_q <= 1'b0;
    end else begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == w_half) begin
        r_clk_q <= 1'b1;
      end else begin
        r_clk_q <= r_clk_q;
      end
    end
  end

  // Shadow ratio and registered status flags.
  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      r_shadow     <= '0;
      r_ratio_ld   <= 1'b0;
      r_div_active <= 1'b0;
    end else begin
      if (w_load) begin
        r_shadow <= ratio;
      end else begin
        r_shadow <= r_shadow;
      end
      r_ratio_ld   <= w_load & (ratio != r_shadow);
      r_div_active <= w_dv;
    end
  end

`ifdef CLK_DIV_PROG_TICK_EN
  logic r_tick;

  // Tick marks the first cycle of each divided period and stays high throughout bypass.
  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_load;
    end
  end

  assign o_tick = r_tick;
`endif

  // Glitch-free only because clk_q is held low whenever the divided path is not selected.
  assign o_clk      = w_dv ? r_clk_q : ref_clk;
  assign div_active = r_div_active;
  assign ratio_ld   = r_ratio_ld;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: expected waveforms are built period-by-period from the ratio sequence.
module tb_clk_div_prog;
  localparam int RATIO_W = 8;

  logic               ref_clk = 1'b0;
  logic               rst;
  logic               en;
  logic [RATIO_W-1:0] ratio;
  logic               o_clk;
  logic               div_active;
  logic               ratio_ld;
`ifdef CLK_DIV_PROG_TICK_EN
  logic               o_tick;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 ref_clk = ~ref_clk;

  clk_div_prog #(.RATIO_W(RATIO_W)) dut (
    .ref_clk    (ref_clk),
    .rst        (rst),
    .en         (en),
    .ratio      (ratio),
    .o_clk      (o_clk),
    .div_active (div_active),
    .ratio_ld   (ratio_ld)
`ifdef CLK_DIV_PROG_TICK_EN
    , .o_tick   (o_tick)
`endif
  );

  task automatic cyc();
    @(posedge ref_clk);
    #1;
  endtask

  // One period of n cycles: floor(n/2) low cycles followed by ceil(n/2) high cycles.
  function automatic void model_period(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i >= (n / 2));
  endfunction

  // Leave the DUT bypassing with the shadow settled on n, then enable; the current cycle is period index 0.
  task automatic enter_div(input int n);
    en = 1'b0;
    ratio = n[RATIO_W-1:0];
    cyc();
    cyc();
    en = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; ratio = 8'd4;
    repeat (3) begin
      cyc();
      n_vec++;
      if (o_clk !== ref_clk || div_active !== 1'b0 || ratio_ld !== 1'b0) begin
        n_err++;
        $display("FAIL reset_high o_clk=%b ref_clk=%b div_active=%b ratio_ld=%b, want o_clk=ref_clk 0 0", o_clk, ref_clk, div_active, ratio_ld);
      end
      @(negedge ref_clk); #1;
      n_vec++;
      if (o_clk !== ref_clk) begin
        n_err++;
        $display("FAIL reset_low o_clk=%b want ref_clk=%b", o_clk, ref_clk);
      end
    end
    cyc();
    rst = 1'b1;
    cyc();
    exp_q.delete(); model_period(4); model_period(4);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (o_clk !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_release_wave idx=%0d o_clk=%b want %b", i, o_clk, exp_q[i]);
      end
      n_vec++;
      if (div_active !== (i >= 1) || ratio_ld !== (i == 0)) begin
        n_err++;
        $display("FAIL reset_release_status idx=%0d div_active=%b ratio_ld=%b want %b %b", i, div_active, ratio_ld, (i >= 1), (i == 0));
      end
      cyc();
    end
  endtask

  task automatic test_ratio_wave(input int n, input int periods);
    enter_div(n);
    exp_q.delete();
    repeat (periods) model_period(n);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (o_clk !== exp_q[i]) begin
        n_err++;
        $display("FAIL ratio_%0d_wave idx=%0d o_clk=%b want %b", n, i, o_clk, exp_q[i]);
      end
      if (i >= 1) begin
        n_vec++;
        if (div_active !== 1'b1) begin
          n_err++;
          $display("FAIL ratio_%0d_active idx=%0d div_active=%b want 1", n, i, div_active);
        end
      end
      cyc();
    end
  endtask

  task automatic test_retune();
    enter_div(6);
    exp_q.delete(); model_period(6); repeat (4) model_period(3);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (o_clk !== exp_q[i] || ratio_ld !== (i == 6)) begin
        n_err++;
        $display("FAIL retune idx=%0d o_clk=%b ratio_ld=%b want %b %b", i, o_clk, ratio_ld, exp_q[i], (i == 6));
      end
      if (i == 2) ratio = 8'd3;
      cyc();
    end
  endtask

  task automatic test_en_drop();
    enter_div(8);
    exp_q.delete(); model_period(8);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (o_clk !== exp_q[i]) begin
        n_err++;
        $display("FAIL en_drop_pre idx=%0d o_clk=%b want %b", i, o_clk, exp_q[i]);
      end
      if (i < 5) cyc();
    end
    en = 1'b0;
    #1;
    n_vec++;
    if (o_clk !== ref_clk) begin
      n_err++;
      $display("FAIL en_drop_immediate o_clk=%b want ref_clk=%b", o_clk, ref_clk);
    end
    @(negedge ref_clk); #1;
    n_vec++;
    if (o_clk !== ref_clk) begin
      n_err++;
      $display("FAIL en_drop_bypass_low o_clk=%b want ref_clk=%b", o_clk, ref_clk);
    end
    cyc();
    n_vec++;
    if (div_active !== 1'b0 || o_clk !== ref_clk) begin
      n_err++;
      $display("FAIL en_drop_status div_active=%b o_clk=%b want 0 and ref_clk=%b", div_active, o_clk, ref_clk);
    end
    cyc(); cyc();
    en = 1'b1;
    #1;
    exp_q.delete(); model_period(8); model_period(8);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (o_clk !== exp_q[i]) begin
        n_err++;
        $display("FAIL en_reassert idx=%0d o_clk=%b want %b", i, o_clk, exp_q[i]);
      end
      cyc();
    end
  endtask

  task automatic test_ratio_one();
    enter_div(4);
    exp_q.delete(); model_period(4);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_clk !== exp_q[i]) begin
        n_err++;
        $display("FAIL ratio_one_finish idx=%0d o_clk=%b want %b", i, o_clk, exp_q[i]);
      end
      if (i == 1) ratio = 8'd1;
      cyc();
    end
    n_vec++;
    if (o_clk !== ref_clk || ratio_ld !== 1'b1 || div_active !== 1'b1) begin
      n_err++;
      $display("FAIL ratio_one_wrap o_clk=%b ratio_ld=%b div_active=%b want ref_clk=%b 1 1", o_clk, ratio_ld, div_active, ref_clk);
    end
    @(negedge ref_clk); #1;
    n_vec++;
    if (o_clk !== ref_clk) begin
      n_err++;
      $display("FAIL ratio_one_bypass o_clk=%b want ref_clk=%b", o_clk, ref_clk);
    end
    cyc();
    n_vec++;
    if (div_active !== 1'b0 || ratio_ld !== 1'b0) begin
      n_err++;
      $display("FAIL ratio_one_settle div_active=%b ratio_ld=%b want 0 0", div_active, ratio_ld);
    end
    ratio = 8'd0;
    cyc();
    n_vec++;
    if (ratio_ld !== 1'b1 || div_active !== 1'b0) begin
      n_err++;
      $display("FAIL ratio_zero_load ratio_ld=%b div_active=%b want 1 0", ratio_ld, div_active);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_vec++;
      if (ratio_ld !== 1'b0 || div_active !== 1'b0 || o_clk !== ref_clk) begin
        n_err++;
        $display("FAIL ratio_zero_hold idx=%0d ratio_ld=%b div_active=%b o_clk=%b want 0 0 %b", i, ratio_ld, div_active, o_clk, ref_clk);
      end
      @(negedge ref_clk); #1;
      n_vec++;
      if (o_clk !== ref_clk) begin
        n_err++;
        $display("FAIL ratio_zero_low idx=%0d o_clk=%b want %b", i, o_clk, ref_clk);
      end
    end
  endtask

  task automatic test_random_retune();
    for (int k = 0; k < 8; k++) begin
      int n, m, x, a, b;
      n = $urandom_range(2, 24);
      m = $urandom_range(2, 24);
      x = $urandom_range(0, 255);
      a = $urandom_range(0, n - 1);
      b = $urandom_range(a, n - 1);
      enter_div(n);
      exp_q.delete(); model_period(n); model_period(m); model_period(m);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (o_clk !== exp_q[i] || ratio_ld !== ((i == n) && (m != n))) begin
          n_err++;
          $display("FAIL random_retune n=%0d m=%0d x=%0d idx=%0d o_clk=%b ratio_ld=%b want %b %b", n, m, x, i, o_clk, ratio_ld, exp_q[i], ((i == n) && (m != n)));
        end
        if (i == a) ratio = x[RATIO_W-1:0];
        if (i == b) ratio = m[RATIO_W-1:0];
        cyc();
      end
    end
  endtask

`ifdef CLK_DIV_PROG_TICK_EN
  task automatic test_tick();
    enter_div(3);
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (o_tick !== ((i % 3) == 0)) begin
        n_err++;
        $display("FAIL tick_divided idx=%0d o_tick=%b want %b", i, o_tick, ((i % 3) == 0));
      end
      cyc();
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_vec++;
      if (o_tick !== 1'b1) begin
        n_err++;
        $display("FAIL tick_bypass idx=%0d o_tick=%b want 1", i, o_tick);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    en = 1'b0;
    ratio = '0;
    test_reset();
    test_ratio_wave(4, 3);
    test_ratio_wave(5, 10);
    test_ratio_wave(2, 6);
    test_ratio_wave(255, 2);
    test_retune();
    test_en_drop();
    test_ratio_one();
    test_random_retune();
`ifdef CLK_DIV_PROG_TICK_EN
    test_tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
